// File: rtl/mem_ctrl.sv
// Memory access controller: turns MemRead/MemWrite strobes from the CPU control FSM
// into one-cycle RAM accesses, waits out the read latency and holds the captured word.
module mem_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataW,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2
    } state_t;

    localparam int CNT_W = 3;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    assign dbg_state = state;

    // Handshake: a strobe is taken at a rising edge only when busy is low; a strobe
    // seen while busy is dropped and latches err. rvalid marks the single cycle in
    // which rdata carries a freshly completed read.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (MemWrite) begin
                        // A colliding read is discarded; the write wins.
                        ram_addr  <= addr;
                        ram_wdata <= dataW;
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= WR;
                        if (MemRead) err <= 1'b1;
                    end else if (MemRead) begin
                        ram_addr <= addr;
                        ram_en   <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (MemRead || MemWrite) err <= 1'b1;
                    if (cnt == CNT_W'(RD_LAT)) begin
                        rdata  <= ram_rdata;
                        rvalid <= 1'b1;
                        busy   <= 1'b0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR: begin
                    if (MemRead || MemWrite) err <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (RD_LAT=2 and RD_LAT=4), each with its own
// pipelined RAM model over a shared backing array; sel picks the instance under test.
module tb_mem_ctrl;

    localparam int DW = 16;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          mem_read, mem_write, sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] dataw;

    logic [DW-1:0] rdata2, wdata2, rrdata2, rdata4, wdata4, rrdata4;
    logic [AW-1:0] raddr2, raddr4;
    logic          rvalid2, busy2, err2, en2, we2;
    logic          rvalid4, busy4, err4, en4, we4;
    logic [1:0]    st2, st4;

    mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) dut2 (
        .CLK(clk), .reset(rst),
        .MemRead(mem_read & ~sel), .MemWrite(mem_write & ~sel),
        .addr(addr), .dataW(dataw),
        .rdata(rdata2), .rvalid(rvalid2), .busy(busy2), .err(err2),
        .ram_en(en2), .ram_we(we2), .ram_addr(raddr2), .ram_wdata(wdata2),
        .ram_rdata(rrdata2), .dbg_state(st2)
    );

    mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(4)) dut4 (
        .CLK(clk), .reset(rst),
        .MemRead(mem_read & sel), .MemWrite(mem_write & sel),
        .addr(addr), .dataW(dataw),
        .rdata(rdata4), .rvalid(rvalid4), .busy(busy4), .err(err4),
        .ram_en(en4), .ram_we(we4), .ram_addr(raddr4), .ram_wdata(wdata4),
        .ram_rdata(rrdata4), .dbg_state(st4)
    );

    // RAM model: data appears RD_LAT cycles after the ram_en cycle
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] pipe2 [0:1];
    logic [DW-1:0] pipe4 [0:3];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (en2 && we2) mem[raddr2] <= wdata2;
        if (en4 && we4) mem[raddr4] <= wdata4;
        pipe2[0] <= (en2 && !we2) ? mem[raddr2] : 16'hDEAD;
        pipe2[1] <= pipe2[0];
        pipe4[0] <= (en4 && !we4) ? mem[raddr4] : 16'hDEAD;
        pipe4[1] <= pipe4[0];
        pipe4[2] <= pipe4[1];
        pipe4[3] <= pipe4[2];
    end
    assign rrdata2 = pipe2[1];
    assign rrdata4 = pipe4[3];

    logic [DW-1:0] o_rdata, o_wdata;
    logic [AW-1:0] o_addr;
    logic          o_rvalid, o_busy, o_err, o_en, o_we;
    assign o_rdata  = sel ? rdata4  : rdata2;
    assign o_wdata  = sel ? wdata4  : wdata2;
    assign o_addr   = sel ? raddr4  : raddr2;
    assign o_rvalid = sel ? rvalid4 : rvalid2;
    assign o_busy   = sel ? busy4   : busy2;
    assign o_err    = sel ? err4    : err2;
    assign o_en     = sel ? en4     : en2;
    assign o_we     = sel ? we4     : we2;

    int            checks = 0;
    int            errors = 0;
    int            rv_cnt = 0;
    int            en_cnt = 0;
    logic          prev_en = 1'b0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rvalid must match the oldest expected word
    always @(negedge clk) begin
        if (o_rvalid) begin
            rv_cnt++;
            check("rvalid_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("rdata", o_rdata, exp_q.pop_front());
        end
        if (o_en) begin
            en_cnt++;
            check("ram_en_gap", prev_en, 0);
        end
        prev_en = o_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // Returns just after the accept edge, when the access outputs are already visible
    task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        mem_read = rd; mem_write = wr; addr = a; dataw = d;
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic check_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check("ram_en", o_en, 1);
        check("ram_we", o_we, we);
        check("ram_addr", o_addr, a);
        check("busy_start", o_busy, 1);
        if (we) check("ram_wdata", o_wdata, d);
    endtask

    task automatic wait_idle(output int n);
        bit done = 0;
        n = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!o_busy) done = 1;
            else n++;
        end
        if (!done) check("busy_timeout", 32'(o_busy), 0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int lat);
        int n, r0, e0;
        r0 = rv_cnt; e0 = en_cnt;
        exp_q.push_back(d);
        issue(1'b1, 1'b0, a, '0);
        check_access(1'b0, a, '0);
        wait_idle(n);
        check("rd_busy_cycles", n, lat + 1);
        tick();
        check("rd_rvalid_count", rv_cnt - r0, 1);
        check("rd_en_pulses", en_cnt - e0, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic both);
        int n, r0, e0;
        r0 = rv_cnt; e0 = en_cnt;
        issue(both, 1'b1, a, d);
        check_access(1'b1, a, d);
        wait_idle(n);
        check("wr_busy_cycles", n, 1);
        repeat (4) tick();
        check("wr_no_rvalid", rv_cnt - r0, 0);
        check("wr_en_pulses", en_cnt - e0, 1);
    endtask

    initial begin
        int n, r0, e0;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; sel = 1'b0;
        addr = '0; dataw = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        preload(8'h10, 16'hBEEF);
        preload(8'h40, 16'h1111);
        preload(8'h50, 16'h5A5A);
        preload(8'h60, 16'h6666);
        do_reset(2);

        repeat (5) begin
            @(negedge clk);
            check("idle_outputs", {o_rdata, o_rvalid, o_busy, o_err, o_en}, 0);
        end
        tick();

        // Basic read, RD_LAT=2
        do_read(8'h10, 16'hBEEF, 2);
        repeat (3) tick();
        check("rdata_hold", o_rdata, 16'hBEEF);
        check("rvalid_low", o_rvalid, 0);

        // Write then read back
        do_write(8'h20, 16'h1234, 1'b0);
        check("err_after_write", o_err, 0);
        do_read(8'h20, 16'h1234, 2);
        check("rdata_after_wr_read", o_rdata, 16'h1234);

        // Simultaneous read and write: write wins, err sticks
        do_write(8'h30, 16'h00AA, 1'b1);
        check("err_collision", o_err, 1);
        check("rdata_untouched", o_rdata, 16'h1234);
        do_read(8'h30, 16'h00AA, 2);
        check("err_sticky", o_err, 1);

        // Write strobe while a read is in flight
        do_reset(1);
        check("err_cleared", o_err, 0);
        r0 = rv_cnt; e0 = en_cnt;
        exp_q.push_back(16'hBEEF);
        issue(1'b1, 1'b0, 8'h10, '0);
        tick();
        issue(1'b0, 1'b1, 8'h40, 16'h7777);
        wait_idle(n);
        check("busy_tail", n, 1);
        tick();
        check("busy_wr_dropped", en_cnt - e0, 1);
        check("busy_read_done", rv_cnt - r0, 1);
        check("err_busy_req", o_err, 1);
        do_read(8'h40, 16'h1111, 2);

        // RD_LAT=4 instance: good read, aborted read, good read
        sel = 1'b1;
        tick();
        do_read(8'h50, 16'h5A5A, 4);
        r0 = rv_cnt;
        issue(1'b1, 1'b0, 8'h60, '0);
        tick();
        tick();
        rst = 1'b1; mem_read = 1'b1; addr = 8'h60;
        tick();
        rst = 1'b0; mem_read = 1'b0;
        check("abort_outputs", {o_rdata, o_rvalid, o_busy, o_err, o_en}, 0);
        repeat (10) tick();
        check("abort_no_rvalid", rv_cnt - r0, 0);
        do_read(8'h50, 16'h5A5A, 4);
        check("rdata_after_abort", o_rdata, 16'h5A5A);

        check("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
